// File: rtl/data_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_lsu
// Brief    : Byte-addressable 32-bit data memory with a load/store unit front
//            end. Requests use a valid/ready handshake. Stores are byte-lane
//            masked. Loads are read synchronously and sign- or zero-extended.
//            A one-entry response buffer gives full throughput.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_lsu #(
    parameter int ADDR_W    = 17,
    parameter int DEPTH     = 32768,
    parameter     INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int c_IDX_W = ADDR_W - 2;

    localparam logic [1:0] c_SIZE_B = 2'b00;
    localparam logic [1:0] c_SIZE_H = 2'b01;
    localparam logic [1:0] c_SIZE_W = 2'b10;

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    logic [31:0] mem [DEPTH];

    state_t             state_q, state_d;
    logic               load_q, load_d;
    logic               err_q, err_d;
    logic [1:0]         size_q, size_d;
    logic               uns_q, uns_d;
    logic [1:0]         off_q, off_d;
    logic [31:0]        rd_word_q;

    logic               w_fire;
    logic               w_err;
    logic               w_hi_nz;
    logic [3:0]         w_mask;
    logic [31:0]        w_wdata_rep;
    logic [c_IDX_W-1:0] w_idx;
    logic [31:0]        w_shifted;
    logic [31:0]        w_ext;

    // Requests are never accepted while reset is held.
    assign req_ready = !rst && ((state_q == S_EMPTY) || rsp_ready);
    assign w_fire    = req_valid && req_ready;
    assign w_idx     = req_addr[ADDR_W-1:2];
    assign w_hi_nz   = (req_addr >> ADDR_W) != 32'd0;

    // Classify the live request: error detection, byte-lane mask and lane-replicated store data.
    always_comb begin
        w_err       = 1'b0;
        w_mask      = 4'b0000;
        w_wdata_rep = req_wdata;
        case (req_size)
            c_SIZE_B: begin
                w_mask      = 4'b0001 << req_addr[1:0];
                w_wdata_rep = {4{req_wdata[7:0]}};
            end
            c_SIZE_H: begin
                w_err       = req_addr[0];
                w_mask      = 4'b0011 << req_addr[1:0];
                w_wdata_rep = {2{req_wdata[15:0]}};
            end
            c_SIZE_W: begin
                w_err  = |req_addr[1:0];
                w_mask = 4'b1111;
            end
            default: begin
                w_err = 1'b1;
            end
        endcase
        if (w_hi_nz) begin
            w_err = 1'b1;
        end
    end

    // Memory array: masked lane writes and synchronous word read; never reset.
    always_ff @(posedge clk) begin
        if (w_fire && !w_err) begin
            if (req_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (w_mask[i]) begin
                        mem[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
                    end
                end
            end else begin
                rd_word_q <= mem[w_idx];
            end
        end
    end

    // Response buffer next state: a fire (re)fills it, a consumed response empties it.
    always_comb begin
        state_d = state_q;
        load_d  = load_q;
        err_d   = err_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        if (w_fire) begin
            state_d = S_FULL;
            load_d  = !req_we;
            err_d   = w_err;
            size_d  = req_size;
            uns_d   = req_unsigned;
            off_d   = req_addr[1:0];
        end else if (rsp_ready) begin
            state_d = S_EMPTY;
        end
    end

    // Response buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            err_q   <= err_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
        end
    end

    // Lane select and extension driven only by the captured request fields.
    always_comb begin
        w_shifted = rd_word_q >> {off_q, 3'b000};
        w_ext     = rd_word_q;
        case (size_q)
            c_SIZE_B: w_ext = uns_q ? {24'd0, w_shifted[7:0]}
                                    : {{24{w_shifted[7]}}, w_shifted[7:0]};
            c_SIZE_H: w_ext = uns_q ? {16'd0, w_shifted[15:0]}
                                    : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default:  w_ext = rd_word_q;
        endcase
    end

    assign rsp_valid = (state_q == S_FULL);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && load_q && !err_q) ? w_ext : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_lsu
// Brief    : Directed self-checking bench for data_mem_lsu.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    data_mem_lsu dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Put a request on the bus (stimulus only).
    task automatic set_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
    endtask

    // Fire one request with rsp_ready=1; returns with the response visible.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        set_req(we, size, uns, addr, wdata);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
        n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", rsp_err); end
        n_checks++; if (rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_word_byte;
        issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin
            n_fail++; $display("FAIL store_rsp: got v=%b e=%b d=%h want 1 0 0", rsp_valid, rsp_err, rsp_rdata); end
        drain();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rsp_clear: got %b want 0", rsp_valid); end
        issue(1'b0, 2'b00, 1'b0, 32'h103, 32'd0);
        n_checks++; if (rsp_rdata !== 32'hFFFFFFDE || rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL lb_signed: got %h e=%b want FFFFFFDE 0", rsp_rdata, rsp_err); end
        issue(1'b0, 2'b00, 1'b1, 32'h100, 32'd0);
        n_checks++; if (rsp_rdata !== 32'h000000EF) begin n_fail++; $display("FAIL lbu: got %h want 000000EF", rsp_rdata); end
        issue(1'b0, 2'b01, 1'b0, 32'h100, 32'd0);
        n_checks++; if (rsp_rdata !== 32'hFFFFBEEF) begin n_fail++; $display("FAIL lh_signed: got %h want FFFFBEEF", rsp_rdata); end
        drain();
    endtask

    task automatic test_half_store;
        issue(1'b1, 2'b01, 1'b0, 32'h102, 32'hFFFF1234);
        drain();
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
        n_checks++; if (rsp_rdata !== 32'h1234BEEF) begin n_fail++; $display("FAIL lw_after_sh: got %h want 1234BEEF", rsp_rdata); end
        issue(1'b0, 2'b01, 1'b1, 32'h102, 32'd0);
        n_checks++; if (rsp_rdata !== 32'h00001234) begin n_fail++; $display("FAIL lhu: got %h want 00001234", rsp_rdata); end
        issue(1'b1, 2'b00, 1'b0, 32'h101, 32'h000000A5);
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
        n_checks++; if (rsp_rdata !== 32'h1234A5EF) begin n_fail++; $display("FAIL lw_after_sb: got %h want 1234A5EF", rsp_rdata); end
        drain();
    endtask

    task automatic test_errors;
        issue(1'b0, 2'b10, 1'b0, 32'h101, 32'd0);
        n_checks++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'd0) begin
            n_fail++; $display("FAIL lw_misaligned: got e=%b d=%h want 1 0", rsp_err, rsp_rdata); end
        issue(1'b1, 2'b01, 1'b0, 32'h103, 32'h0000FFFF);
        n_checks++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'd0) begin
            n_fail++; $display("FAIL sh_misaligned: got e=%b d=%h want 1 0", rsp_err, rsp_rdata); end
        issue(1'b1, 2'b11, 1'b0, 32'h100, 32'h00000000);
        n_checks++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'd0) begin
            n_fail++; $display("FAIL size_illegal: got e=%b d=%h want 1 0", rsp_err, rsp_rdata); end
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
        n_checks++; if (rsp_rdata !== 32'h1234A5EF || rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL mem_unchanged: got %h e=%b want 1234A5EF 0", rsp_rdata, rsp_err); end
        drain();
    endtask

    task automatic test_out_of_range;
        issue(1'b1, 2'b10, 1'b0, 32'h0, 32'h11111111);
        issue(1'b1, 2'b10, 1'b0, 32'h20000, 32'hCAFEF00D);
        n_checks++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL oor_store_err: got %b want 1", rsp_err); end
        issue(1'b0, 2'b10, 1'b0, 32'h20000, 32'd0);
        n_checks++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'd0) begin
            n_fail++; $display("FAIL oor_load_err: got e=%b d=%h want 1 0", rsp_err, rsp_rdata); end
        issue(1'b0, 2'b10, 1'b0, 32'h0, 32'd0);
        n_checks++; if (rsp_rdata !== 32'h11111111) begin n_fail++; $display("FAIL no_alias: got %h want 11111111", rsp_rdata); end
        drain();
    endtask

    task automatic test_store_then_load;
        set_req(1'b1, 2'b10, 1'b0, 32'h200, 32'h55667788);
        @(posedge clk); #1;
        set_req(1'b0, 2'b10, 1'b0, 32'h200, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_checks++; if (rsp_rdata !== 32'h55667788 || rsp_valid !== 1'b1) begin
            n_fail++; $display("FAIL raw_next_cycle: got %h v=%b want 55667788 1", rsp_rdata, rsp_valid); end
        drain();
    endtask

    task automatic test_back_to_back;
        rsp_ready = 1'b0;
        set_req(1'b0, 2'b00, 1'b0, 32'h100, 32'd0);
        @(posedge clk); #1;
        set_req(1'b0, 2'b10, 1'b1, 32'h0, 32'd0);
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL full_not_ready: got %b want 0", req_ready); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hFFFFFFEF || req_ready !== 1'b0) begin
                n_fail++; $display("FAIL hold_%0d: got v=%b d=%h rdy=%b want 1 FFFFFFEF 0", i, rsp_valid, rsp_rdata, req_ready); end
        end
        rsp_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b want 1", req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11111111) begin
            n_fail++; $display("FAIL second_rsp: got v=%b d=%h want 1 11111111", rsp_valid, rsp_rdata); end
        @(posedge clk); #1;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b want 0", rsp_valid); end
    endtask

    task automatic test_reset_mid;
        rsp_ready = 1'b0;
        issue(1'b0, 2'b10, 1'b0, 32'h200, 32'd0);
        rst = 1'b1;
        set_req(1'b1, 2'b10, 1'b0, 32'h200, 32'h00000000);
        @(posedge clk); #1;
        n_checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got v=%b d=%h e=%b want 0 0 0", rsp_valid, rsp_rdata, rsp_err); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset: got rdy=%b v=%b want 1 0", req_ready, rsp_valid); end
        issue(1'b0, 2'b10, 1'b0, 32'h200, 32'd0);
        n_checks++; if (rsp_rdata !== 32'h55667788) begin n_fail++; $display("FAIL mem_kept: got %h want 55667788", rsp_rdata); end
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
        n_checks++; if (rsp_rdata !== 32'h1234A5EF) begin n_fail++; $display("FAIL mem_kept2: got %h want 1234A5EF", rsp_rdata); end
        drain();
    endtask

    initial begin
        test_reset();
        test_word_byte();
        test_half_store();
        test_errors();
        test_out_of_range();
        test_store_then_load();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
